// File: rtl/execute_unit.sv
// execute_unit: single-cycle ALU plus shift-add multiplier, result held under a valid/ready handshake.
module execute_unit #(
  parameter int WORDSIZE = 64,
  parameter int ADDRW    = 5,
  parameter int SHW      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          alu_op,
  input  logic [WORDSIZE-1:0] rs1_val,
  input  logic [WORDSIZE-1:0] rs2_val,
  input  logic [ADDRW-1:0]    rd_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] rd_out,
  output logic [ADDRW-1:0]    rd_addr_out,
  output logic                illegal,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, rd_q, rd_d;
  logic [WORDSIZE-1:0] alu_res, acc_sum;
  logic [ADDRW-1:0]    addr_q, addr_d;
  logic [SHW-1:0]      cnt_q, cnt_d, sh;
  logic                ill_q, ill_d, alu_ill;
  assign sh          = rs2_val[SHW-1:0];
  assign acc_sum     = acc_q + (b_q[0] ? a_q : '0);
  assign in_ready    = state_q == IDLE;
  assign busy        = state_q == MUL;
  assign out_valid   = state_q == DONE;
  assign rd_out      = rd_q;
  assign rd_addr_out = addr_q;
  assign illegal     = ill_q;
  always_comb begin
    alu_ill = 1'b0;
    alu_res = '0;
    case (alu_op)
      4'd0: alu_res = rs1_val + rs2_val;
      4'd1: alu_res = rs1_val - rs2_val;
      4'd2: alu_res = rs1_val & rs2_val;
      4'd3: alu_res = rs1_val | rs2_val;
      4'd4: alu_res = rs1_val ^ rs2_val;
      4'd5: alu_res = rs1_val << sh;
      4'd6: alu_res = rs1_val >> sh;
      4'd7: alu_res = WORDSIZE'($signed(rs1_val) >>> sh);
      4'd8: alu_res = {{(WORDSIZE-1){1'b0}}, $signed(rs1_val) < $signed(rs2_val)};
      4'd9: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (in_valid) begin
        addr_d = rd_addr;
        if (alu_op == 4'd9) begin
          state_d = MUL;
          a_d     = rs1_val;
          b_d     = rs2_val;
          acc_d   = '0;
          cnt_d   = '0;
          ill_d   = 1'b0;
        end else begin
          state_d = DONE;
          rd_d    = alu_res;
          ill_d   = alu_ill;
        end
      end
      MUL: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WORDSIZE-1)) begin
          state_d = DONE;
          rd_d    = acc_sum;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed vector table, handshake corner sequences and random ops against an arithmetic model.
module tb_execute_unit;
  localparam int W = 64;
  localparam int A = 5;
  logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0]   alu_op = 0;
  logic [W-1:0] rs1_val = 0, rs2_val = 0;
  logic [A-1:0] rd_addr = 0;
  logic         in_ready, out_valid, illegal, busy;
  logic [W-1:0] rd_out;
  logic [A-1:0] rd_addr_out;
  int           n_vec = 0, n_err = 0;
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [A-1:0] rd;
    logic [W-1:0] res;
    logic         ill;
  } vec_t;
  vec_t vecs[13];
  execute_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr), .out_valid(out_valid),
    .out_ready(out_ready), .rd_out(rd_out), .rd_addr_out(rd_addr_out), .illegal(illegal), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic ill);
    int sh = int'(b[5:0]);
    ill = 0;
    res = 0;
    case (op)
      0: res = a + b;
      1: res = a - b;
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = a << sh;
      6: res = a >> sh;
      7: res = a[W-1] ? ~((~a) >> sh) : a >> sh;
      8: res = ($signed(a) < $signed(b)) ? 1 : 0;
      9: res = a * b;
      default: ill = 1;
    endcase
  endfunction
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [A-1:0] rd, input logic [W-1:0] res, input logic ill, input int hold);
    int cyc = 0, nbusy = 0;
    logic [W-1:0] held;
    while (!in_ready && cyc < 200) begin tick(); cyc++; end
    chk("in_ready_before_op", in_ready, 1);
    alu_op = op; rs1_val = a; rs2_val = b; rd_addr = rd; in_valid = 1; out_ready = (hold == 0);
    tick();
    in_valid = 0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin nbusy += busy; tick(); cyc++; end
    chk($sformatf("latency_op%0d", op), cyc, (op == 9) ? 65 : 1);
    chk($sformatf("busy_cycles_op%0d", op), nbusy, (op == 9) ? 64 : 0);
    chk($sformatf("rd_out_op%0d", op), rd_out, res);
    chk($sformatf("rd_addr_out_op%0d", op), rd_addr_out, rd);
    chk($sformatf("illegal_op%0d", op), illegal, ill);
    held = rd_out;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_stable", rd_out, held);
      chk("hold_valid", {in_ready, out_valid}, 2'b01);
    end
    out_ready = 1;
    tick();
    chk("after_handshake", {out_valid, in_ready}, 2'b01);
  endtask
  initial begin
    logic [W-1:0] ra, rb, rr;
    logic [3:0]   rop;
    logic         ri;
    logic         seen;
    vecs[0]  = '{4'd0, 64'h5f11_e01a, 64'd1, 5'd4, 64'h5f11_e01b, 1'b0};
    vecs[1]  = '{4'd1, 64'd0, 64'd1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2]  = '{4'd7, 64'h8000_0000_0000_0000, 64'd68, 5'd2, 64'hF800_0000_0000_0000, 1'b0};
    vecs[3]  = '{4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'd1, 1'b0};
    vecs[4]  = '{4'd8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'd0, 1'b0};
    vecs[5]  = '{4'd2, 64'hff00_ff00, 64'h0ff0_0ff0, 5'd6, 64'h0f00_0f00, 1'b0};
    vecs[6]  = '{4'd3, 64'hff00_ff00, 64'h0ff0_0ff0, 5'd7, 64'hfff0_fff0, 1'b0};
    vecs[7]  = '{4'd4, 64'hff00_ff00, 64'h0ff0_0ff0, 5'd8, 64'hf0f0_f0f0, 1'b0};
    vecs[8]  = '{4'd5, 64'd1, 64'd63, 5'd9, 64'h8000_0000_0000_0000, 1'b0};
    vecs[9]  = '{4'd6, 64'h8000_0000_0000_0000, 64'd64, 5'd10, 64'h8000_0000_0000_0000, 1'b0};
    vecs[10] = '{4'd12, 64'd7, 64'd9, 5'd11, 64'd0, 1'b1};
    vecs[11] = '{4'd9, 64'h1_0000_0001, 64'd3, 5'd12, 64'h3_0000_0003, 1'b0};
    vecs[12] = '{4'd0, 64'd2, 64'd3, 5'd0, 64'd5, 1'b0};
    repeat (2) tick();
    rst = 0;
    tick();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rd_out", rd_out, 0);
    chk("reset_rd_addr_out", rd_addr_out, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_busy", busy, 0);
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].ill, 0);
    // backpressure with a competing bundle that must be ignored
    alu_op = 4'd0; rs1_val = 64'd10; rs2_val = 64'd20; rd_addr = 5'd13; in_valid = 1; out_ready = 0;
    tick();
    chk("bp_valid", out_valid, 1);
    alu_op = 4'd1; rs1_val = 64'd99; rs2_val = 64'd1; rd_addr = 5'd14;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rd_out", rd_out, 64'd30);
      chk("bp_rd_addr", rd_addr_out, 5'd13);
      chk("bp_ready_valid", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 0; out_ready = 1;
    tick();
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    tick();
    chk("bp_no_ghost", out_valid, 0);
    // reset during multiply
    alu_op = 4'd9; rs1_val = 64'd5; rs2_val = 64'd5; rd_addr = 5'd15; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (19) tick();
    chk("mid_mul_busy", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("abort_state", {busy, in_ready, out_valid}, 3'b010);
    seen = 0;
    for (int i = 0; i < 80; i++) begin tick(); seen |= out_valid; end
    chk("abort_no_valid", seen, 0);
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 200)) : {$urandom, $urandom};
      model(rop, ra, rb, rr, ri);
      run_op(rop, ra, rb, 5'($urandom), rr, ri, $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
